ili_spi_arbiter: RTL
====================

Name: ili_spi_arbiter

Overview:
Shares the single SPI byte engine (spi_ctrl + spi_shift) between up to N_REQ byte-stream requesters, e.g. the ILI9341 init controller (req 0) and a pixel/draw command streamer (req 1).
Arbitration is round-robin per transaction, where a transaction is one or more bytes ending on a byte flagged last. The block owns chip-select framing, setup/hold/gap timing and the D/C line, and issues one send pulse per byte on the engine's send/sent handshake.

Parameters:
N_REQ, 2, number of requesters (2..4)
CS_SETUP, 2, cycles cs is low before the first send of a transaction (>=1)
CS_HOLD, 2, cycles cs stays low after the final done (>=1)
CS_GAP, 4, minimum cycles cs is high between transactions (>=1)
TIMEOUT, 1024, cycles the granted requester may leave req_valid low mid-transaction before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
req_valid  in  N_REQ  requester i has a byte presented
req_data  in  8*N_REQ  byte of requester i, slice [8i+7:8i]
req_dc  in  N_REQ  D/C value for that byte (0 = command, 1 = data)
req_last  in  N_REQ  byte ends requester i's transaction
req_ready  out  N_REQ  one-cycle accept pulse for requester i's byte
grant  out  N_REQ  one-hot ownership, held for the whole transaction
spi_data  out  8  byte to the shift register
spi_dc  out  1  D/C pin
spi_cs  out  1  chip select, active low
spi_send  out  1  one-cycle start pulse to spi_ctrl
spi_done  in  1  byte-complete pulse from spi_ctrl
busy  out  1  high in any state other than IDLE
err_timeout  out  1  one-cycle pulse on a transaction abort

Behaviour:
- Reset (rst=0 at clk edge) is synchronous and active-low. All outputs reset to 0 except spi_cs=1. State goes to IDLE, RR pointer to 0, counters to 0. A reset mid-transaction abandons it; any pending spi_done is ignored.
- States are IDLE, SETUP, LOAD, SEND, WAIT, HOLD, GAP.
- IDLE: if any req_valid, grant the first valid index at or after the pointer, searching upward with wrap. Latch grant, drive spi_cs=0 and go to SETUP on the next edge. The requester's byte is not consumed in IDLE.
- SETUP: count CS_SETUP cycles, then go to LOAD.
- LOAD (granted index g):
  - If req_valid[g]=1: req_ready[g]=1 combinationally this cycle. Register spi_data, spi_dc and last_q. Go to SEND.
  - Otherwise increment the idle counter. When it reaches TIMEOUT, pulse err_timeout and go to HOLD (abort).
  - The idle counter clears on every accept.
- SEND: spi_send=1 for exactly one cycle, then go to WAIT. spi_data and spi_dc stay stable from SEND until the next LOAD accept.
- WAIT: on spi_done, go to HOLD if last_q=1, else go to LOAD. spi_done seen in any other state is ignored.
- HOLD: spi_cs stays 0 for CS_HOLD cycles. Then spi_cs=1, grant clears, pointer becomes (g+1) mod N_REQ, go to GAP.
- GAP: CS_GAP cycles with spi_cs=1, then IDLE. Requests are not sampled in GAP.
- Per-byte latency: accept in LOAD -> spi_send on the next cycle.
- First-byte latency from req_valid rising in IDLE: IDLE(1) + SETUP(CS_SETUP) + LOAD(1), then send.
- grant is stable and one-hot from SETUP through HOLD; all zeros in IDLE and GAP.
- busy = (state != IDLE).
- Non-granted requesters never get req_ready. Their req_valid can stay high indefinitely without effect.
- Simultaneous requests resolve by the RR pointer. After reset, req 0 wins a tie.
- Counters are sized $clog2(max param)+1. The TIMEOUT counter saturates and does not wrap.

Decomposition:
- Package ili_spi_pkg: state enum (st_e, 3-bit), BYTE_W=8, default timing constants.
- Sub-module ili_rr_arb: combinational round-robin pick (req vector + pointer -> one-hot plus index).
- The top contains the FSM, counters and datapath registers.

Test Plan:
- Single transaction: req0 sends 0x01 (dc=0, last=1).
  - cs falls the cycle after valid.
  - send pulses 4 cycles after valid (CS_SETUP=2).
  - spi_data=0x01, dc=0.
  - cs rises 2 cycles after done, then is high for 4 cycles.
- Multi-byte: req1 sends 0x2A (dc=0), 0x00, 0x00, 0x00, 0xEF (dc=1, last on 0xEF).
  - Exactly 5 send pulses and 5 req_ready pulses.
  - cs stays low throughout; grant=2'b10 throughout.
- Contention: req0 and req1 both valid continuously with 1-byte transactions.
  - Grant order is 0, 1, 0, 1.
  - Non-granted req_ready is always 0.
- Timeout with TIMEOUT=8: req0 sends byte 0xB1 (last=0), then drops valid.
  - err_timeout pulses 8 cycles into LOAD.
  - cs rises after CS_HOLD; the pointer moves to 1.
- Reset mid-WAIT: assert rst=0 for 1 cycle.
  - Next cycle: cs=1, grant=0, busy=0.
  - A late spi_done produces no send.
  - The next request is served by req0 first.
- Spurious spi_done in IDLE and GAP: no state change and no outputs toggle.

Source files
------------

// File: rtl/ili_spi_pkg.sv
// Shared types and default timing for the ILI SPI engine arbiter.
package ili_spi_pkg;

  localparam int BYTE_W       = 8;
  localparam int N_REQ_DEF    = 2;
  localparam int CS_SETUP_DEF = 2;
  localparam int CS_HOLD_DEF  = 2;
  localparam int CS_GAP_DEF   = 4;
  localparam int TIMEOUT_DEF  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } st_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ili_rr_arb.sv
// Combinational round-robin pick: first request at or above the pointer, wrapping.
module ili_rr_arb
  import ili_spi_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  // scan upward from the pointer and keep the first hit
  always_comb begin
    int k;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(ptr_i) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!gnt_vld_o && req_i[k]) begin
        gnt_vld_o   = 1'b1;
        gnt_idx_o   = IDX_W'(k);
        gnt_oh_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ili_spi_arbiter.sv
// Round-robin sharing of one SPI byte engine with CS framing and D/C control.
//
// state | meaning
// IDLE  | cs high, waiting for any requester
// SETUP | cs low, CS_SETUP cycles before first byte
// LOAD  | waiting for the granted requester's next byte
// SEND  | one-cycle send pulse to the engine
// WAIT  | waiting for the engine's done pulse
// HOLD  | cs still low for CS_HOLD cycles after last byte or abort
// GAP   | cs high for CS_GAP cycles before re-arbitrating
module ili_spi_arbiter
  import ili_spi_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int CS_SETUP = CS_SETUP_DEF,
  parameter int CS_HOLD  = CS_HOLD_DEF,
  parameter int CS_GAP   = CS_GAP_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [BYTE_W*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_dc_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic [BYTE_W-1:0]       spi_data_o,
  output logic                    spi_dc_o,
  output logic                    spi_cs_o,
  output logic                    spi_send_o,
  input  logic                    spi_done_i,
  output logic                    busy_o,
  output logic                    err_timeout_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP)) + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  st_e               state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              dc_q, dc_d;
  logic              last_q, last_d;

  logic [N_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              g_valid;
  logic [TMO_W-1:0]  tmo_inc;
  logic              tmo_hit;

  ili_rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_arb (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .gnt_vld_o (pick_vld)
  );

  assign g_valid = |(req_valid_i & grant_q);
  // idle counter saturates so a long stall can never wrap back below the limit
  assign tmo_inc = (tmo_q >= TMO_W'(TIMEOUT)) ? tmo_q : tmo_q + TMO_W'(1);
  assign tmo_hit = (tmo_inc >= TMO_W'(TIMEOUT));

  // state, counters and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      dc_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      last_q  <= last_d;
    end
  end

  // next-state, counter and byte-capture logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    dc_d    = dc_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tmo_d = '0;
        if (pick_vld) begin
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q >= CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        if (g_valid) begin
          data_d  = req_data_i[BYTE_W*int'(gidx_q) +: BYTE_W];
          dc_d    = req_dc_i[gidx_q];
          last_d  = req_last_i[gidx_q];
          tmo_d   = '0;
          state_d = ST_SEND;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_hit) begin
            cnt_d   = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (spi_done_i) begin
          cnt_d   = '0;
          state_d = last_q ? ST_HOLD : ST_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q >= CNT_W'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          grant_d = '0;
          ptr_d   = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q >= CNT_W'(CS_GAP - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs decoded from the current state and granted requester
  always_comb begin
    busy_o        = (state_q != ST_IDLE);
    spi_cs_o      = (state_q == ST_IDLE) || (state_q == ST_GAP);
    spi_send_o    = (state_q == ST_SEND);
    grant_o       = grant_q;
    req_ready_o   = (state_q == ST_LOAD) ? (grant_q & req_valid_i) : '0;
    err_timeout_o = (state_q == ST_LOAD) && !g_valid && tmo_hit;
    spi_data_o    = data_q;
    spi_dc_o      = dc_q;
  end

endmodule
